distributor_rr_reg: RTL and testbench

// - Successor slice distributor between the slice FIFO (queue_token, show-ahead) and NUM_PARSER 2nd-level parsers.
// - Pops one slice per cycle when any eligible parser is ready. Broadcasts the registered payload, with a one-hot valid to the granted parser.
// - Adds over the previous generation:
//   - parametrised field widths;
//   - registered outputs;
//   - fair rotate-past-winner round-robin, or a fixed-priority mode;
//   - per-parser hold-off mask, which covers parsers whose ready deasserts late;
//   - dispatch counter.

---
 rtl/distributor_rr_reg.sv | 134 +++++++++++++
 tb/tb_distributor_rr_reg.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/distributor_rr_reg.sv
// Slice distributor: pops the show-ahead slice FIFO and hands each slice to one of
// NUM_PARSER parsers via a registered payload and a one-hot valid strobe.
module distributor_rr_reg #(
    parameter int                    NUM_PARSER = 6,
    parameter logic [NUM_PARSER-1:0] BASE_INIT  = NUM_PARSER'(1),
    parameter int                    DATA_W     = 144,
    parameter int                    POS_W      = 16,
    parameter int                    ADDR_W     = 17,
    parameter int                    GARB_W     = 3,
    parameter int                    MODE       = 0,
    parameter int                    HOLDOFF    = 2,
    parameter int                    CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_W-1:0]     data_in,
    input  logic [POS_W-1:0]      position_in,
    input  logic [ADDR_W-1:0]     address_in,
    input  logic [GARB_W-1:0]     garbage_in,
    input  logic                  lit_flag_in,
    input  logic                  valid_in,
    input  logic                  stop,
    input  logic [NUM_PARSER-1:0] ready,
    output logic                  rdreq,
    output logic [DATA_W-1:0]     data_out,
    output logic [POS_W-1:0]      position_out,
    output logic [ADDR_W-1:0]     address_out,
    output logic [GARB_W-1:0]     garbage_out,
    output logic                  lit_flag_out,
    output logic [NUM_PARSER-1:0] valid_out,
    output logic [CNT_W-1:0]      dispatch_cnt
);

    localparam int IDX_W = (NUM_PARSER > 1) ? $clog2(NUM_PARSER) : 1;
    localparam int HC_W  = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;

    logic                  stop_q;
    logic [NUM_PARSER-1:0] base_q, base_d;
    logic [NUM_PARSER-1:0] valid_q, valid_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [HC_W-1:0]       hcnt_q [NUM_PARSER];
    logic [HC_W-1:0]       hcnt_d [NUM_PARSER];
    logic [DATA_W-1:0]     data_q;
    logic [POS_W-1:0]      pos_q;
    logic [ADDR_W-1:0]     addr_q;
    logic [GARB_W-1:0]     garb_q;
    logic                  lit_q;

    logic [NUM_PARSER-1:0] eligible, rot_elig, rot_first, grant_rr, grant_fix, grant;
    logic [IDX_W-1:0]      base_idx;
    logic                  fire;

    always_comb begin
        for (int i = 0; i < NUM_PARSER; i++) begin
            eligible[i] = ready[i] & (hcnt_q[i] == '0);
        end
    end

    always_comb begin
        base_idx = '0;
        for (int i = 0; i < NUM_PARSER; i++) begin
            if (base_q[i]) base_idx = IDX_W'(i);
        end
    end

    // Rotate so base sits at bit 0, take the lowest set bit, rotate back.
    assign rot_elig  = (eligible >> base_idx) | (eligible << (NUM_PARSER - base_idx));
    assign rot_first = rot_elig & (~rot_elig + NUM_PARSER'(1));
    assign grant_rr  = (rot_first << base_idx) | (rot_first >> (NUM_PARSER - base_idx));
    assign grant_fix = eligible & (~eligible + NUM_PARSER'(1));
    assign grant     = (MODE == 1) ? grant_fix : grant_rr;

    assign fire  = valid_in & (|eligible) & ~stop_q & ~rst;
    assign rdreq = fire;

    always_comb begin
        base_d  = base_q;
        valid_d = '0;
        cnt_d   = cnt_q;
        for (int i = 0; i < NUM_PARSER; i++) begin
            hcnt_d[i] = (hcnt_q[i] != '0) ? hcnt_q[i] - HC_W'(1) : hcnt_q[i];
        end
        if (fire) begin
            base_d  = {grant[NUM_PARSER-2:0], grant[NUM_PARSER-1]};
            valid_d = grant;
            cnt_d   = cnt_q + CNT_W'(1);
            for (int i = 0; i < NUM_PARSER; i++) begin
                if (grant[i]) hcnt_d[i] = HC_W'(HOLDOFF);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stop_q  <= 1'b0;
            base_q  <= BASE_INIT;
            valid_q <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            pos_q   <= '0;
            addr_q  <= '0;
            garb_q  <= '0;
            lit_q   <= 1'b0;
            for (int i = 0; i < NUM_PARSER; i++) hcnt_q[i] <= '0;
        end else begin
            stop_q  <= stop;
            base_q  <= base_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
            for (int i = 0; i < NUM_PARSER; i++) hcnt_q[i] <= hcnt_d[i];
            if (fire) begin
                data_q <= data_in;
                pos_q  <= position_in;
                addr_q <= address_in;
                garb_q <= garbage_in;
                lit_q  <= lit_flag_in;
            end
        end
    end

    // A non-one-hot BASE_INIT shows up here on the first cycle out of reset.
    always_ff @(posedge clk) begin
        if (!rst) assert ($onehot(base_q)) else $error("distributor base pointer not one-hot");
    end

    assign data_out     = data_q;
    assign position_out = pos_q;
    assign address_out  = addr_q;
    assign garbage_out  = garb_q;
    assign lit_flag_out = lit_q;
    assign valid_out    = valid_q;
    assign dispatch_cnt = cnt_q;

endmodule

// File: tb/tb_distributor_rr_reg.sv
// Bench for distributor_rr_reg: a round-robin instance driven from a vector table,
// plus a fixed-priority instance exercised by a short hand-written sequence.
module tb_distributor_rr_reg;

    localparam int NP = 6;
    localparam int DW = 144;
    localparam int PW = 16;
    localparam int AW = 17;
    localparam int GW = 3;
    localparam int CW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] data_in = '0;
    logic [PW-1:0] position_in = '0;
    logic [AW-1:0] address_in = '0;
    logic [GW-1:0] garbage_in = '0;
    logic          lit_flag_in = 1'b0;
    logic          valid_in = 1'b0;
    logic          stop = 1'b0;
    logic [NP-1:0] ready = '0;

    logic          rdreq_0, rdreq_1;
    logic [DW-1:0] data_0, data_1;
    logic [PW-1:0] pos_0, pos_1;
    logic [AW-1:0] addr_0, addr_1;
    logic [GW-1:0] garb_0, garb_1;
    logic          lit_0, lit_1;
    logic [NP-1:0] vo_0, vo_1;
    logic [CW-1:0] cnt_0, cnt_1;

    always #5 clk = ~clk;

    distributor_rr_reg dut0 (
        .clk(clk), .rst(rst), .data_in(data_in), .position_in(position_in),
        .address_in(address_in), .garbage_in(garbage_in), .lit_flag_in(lit_flag_in),
        .valid_in(valid_in), .stop(stop), .ready(ready), .rdreq(rdreq_0),
        .data_out(data_0), .position_out(pos_0), .address_out(addr_0),
        .garbage_out(garb_0), .lit_flag_out(lit_0), .valid_out(vo_0), .dispatch_cnt(cnt_0)
    );

    distributor_rr_reg #(.MODE(1), .HOLDOFF(0)) dut1 (
        .clk(clk), .rst(rst), .data_in(data_in), .position_in(position_in),
        .address_in(address_in), .garbage_in(garbage_in), .lit_flag_in(lit_flag_in),
        .valid_in(valid_in), .stop(stop), .ready(ready), .rdreq(rdreq_1),
        .data_out(data_1), .position_out(pos_1), .address_out(addr_1),
        .garbage_out(garb_1), .lit_flag_out(lit_1), .valid_out(vo_1), .dispatch_cnt(cnt_1)
    );

    typedef struct {
        logic          rst;
        logic          vin;
        logic          stp;
        logic [NP-1:0] rdy;
        logic          exp_rd;
        logic [NP-1:0] exp_vo;
    } vec_t;

    typedef struct {
        logic          from_rst;
        logic [NP-1:0] vo;
        logic [DW-1:0] data;
        logic [PW-1:0] pos;
        logic [AW-1:0] addr;
        logic [GW-1:0] garb;
        logic          lit;
        logic [CW-1:0] cnt;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    function automatic vec_t v(input logic r, input logic vi, input logic s,
                               input logic [NP-1:0] rd, input logic er, input logic [NP-1:0] ev);
        vec_t x;
        x.rst = r; x.vin = vi; x.stp = s; x.rdy = rd; x.exp_rd = er; x.exp_vo = ev;
        return x;
    endfunction

    task automatic drive_payload();
        data_in     = {$urandom(), $urandom(), $urandom(), $urandom(), 16'($urandom())};
        position_in = PW'($urandom());
        address_in  = AW'($urandom());
        garbage_in  = GW'($urandom());
        lit_flag_in = 1'($urandom());
    endtask

    task automatic check_out(input exp_t e);
        chk("valid_out", 256'(vo_0), 256'(e.vo));
        chk("data_out", 256'(data_0), 256'(e.data));
        chk("position_out", 256'(pos_0), 256'(e.pos));
        chk("address_out", 256'(addr_0), 256'(e.addr));
        chk("garbage_out", 256'(garb_0), 256'(e.garb));
        chk("lit_flag_out", 256'(lit_0), 256'(e.lit));
        chk("dispatch_cnt", 256'(cnt_0), 256'(e.cnt));
        if (e.from_rst) begin
            chk("m1_reset_valid_out", 256'(vo_1), 256'(0));
            chk("m1_reset_cnt", 256'(cnt_1), 256'(0));
        end
    endtask

    initial begin
        exp_t          m;
        exp_t          e;
        logic [DW-1:0] prev_data;
        logic [PW-1:0] prev_pos;

        // reset with a valid head present: rdreq must stay low
        tbl.push_back(v(1, 1, 0, 6'h3F, 0, 6'h00));
        tbl.push_back(v(1, 1, 0, 6'h3F, 0, 6'h00));
        // full streaming: rotation 0..5 twice
        for (int i = 0; i < 12; i++) tbl.push_back(v(0, 1, 0, 6'h3F, 1, NP'(1) << (i % 6)));
        // empty FIFO: nothing moves, base stays at parser 0
        tbl.push_back(v(0, 0, 0, 6'h3F, 0, 6'h00));
        tbl.push_back(v(0, 0, 0, 6'h3F, 0, 6'h00));
        tbl.push_back(v(0, 1, 0, 6'h3F, 1, 6'h01));
        // single ready parser: hold-off spaces grants three cycles apart
        tbl.push_back(v(0, 1, 0, 6'h04, 1, 6'h04));
        tbl.push_back(v(0, 1, 0, 6'h04, 0, 6'h00));
        tbl.push_back(v(0, 1, 0, 6'h04, 0, 6'h00));
        tbl.push_back(v(0, 1, 0, 6'h04, 1, 6'h04));
        tbl.push_back(v(0, 1, 0, 6'h04, 0, 6'h00));
        tbl.push_back(v(0, 1, 0, 6'h04, 0, 6'h00));
        tbl.push_back(v(0, 1, 0, 6'h04, 1, 6'h04));
        // stop: one more pop on the stop cycle, resume one cycle after release
        tbl.push_back(v(0, 1, 0, 6'h3F, 1, 6'h08));
        tbl.push_back(v(0, 1, 1, 6'h3F, 1, 6'h10));
        for (int i = 0; i < 4; i++) tbl.push_back(v(0, 1, 1, 6'h3F, 0, 6'h00));
        tbl.push_back(v(0, 1, 0, 6'h3F, 0, 6'h00));
        tbl.push_back(v(0, 1, 0, 6'h3F, 1, 6'h20));
        tbl.push_back(v(0, 1, 0, 6'h3F, 1, 6'h01));
        tbl.push_back(v(0, 1, 0, 6'h3F, 1, 6'h02));
        // reset mid-stream, then restart at BASE_INIT
        tbl.push_back(v(1, 1, 0, 6'h3F, 0, 6'h00));
        tbl.push_back(v(0, 1, 0, 6'h3F, 1, 6'h01));
        tbl.push_back(v(0, 1, 0, 6'h3F, 1, 6'h02));
        // sparse ready: skip ahead, wrap past the top, no-one ready, masked parser skipped
        tbl.push_back(v(0, 1, 0, 6'h18, 1, 6'h08));
        tbl.push_back(v(0, 1, 0, 6'h03, 1, 6'h01));
        tbl.push_back(v(0, 1, 0, 6'h00, 0, 6'h00));
        tbl.push_back(v(0, 1, 0, 6'h23, 1, 6'h02));

        m = '{from_rst: 1'b1, vo: '0, data: '0, pos: '0, addr: '0, garb: '0, lit: 1'b0, cnt: '0};

        foreach (tbl[k]) begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check_out(e);
            end
            rst      = tbl[k].rst;
            valid_in = tbl[k].vin;
            stop     = tbl[k].stp;
            ready    = tbl[k].rdy;
            drive_payload();
            #1;
            chk("rdreq", 256'(rdreq_0), 256'(tbl[k].exp_rd));
            vectors++;
            if (tbl[k].rst) begin
                m = '{from_rst: 1'b1, vo: '0, data: '0, pos: '0, addr: '0, garb: '0, lit: 1'b0, cnt: '0};
            end else begin
                m.from_rst = 1'b0;
                if (tbl[k].exp_rd) begin
                    m.vo   = tbl[k].exp_vo;
                    m.data = data_in;
                    m.pos  = position_in;
                    m.addr = address_in;
                    m.garb = garbage_in;
                    m.lit  = lit_flag_in;
                    m.cnt  = m.cnt + 1;
                end else begin
                    m.vo = '0;
                end
            end
            sb.push_back(m);
        end
        @(negedge clk);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check_out(e);
        end

        // fixed-priority instance: lowest eligible index always wins
        prev_data = '0;
        prev_pos  = '0;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            if (i > 0) begin
                chk("m1_valid_out", 256'(vo_1), 256'(6'h08));
                chk("m1_data_out", 256'(data_1), 256'(prev_data));
                chk("m1_position_out", 256'(pos_1), 256'(prev_pos));
            end
            ready    = 6'h28;
            valid_in = 1'b1;
            stop     = 1'b0;
            drive_payload();
            prev_data = data_in;
            prev_pos  = position_in;
            #1;
            chk("m1_rdreq", 256'(rdreq_1), 256'(1));
            vectors++;
        end
        @(negedge clk);
        chk("m1_valid_out", 256'(vo_1), 256'(6'h08));
        ready = 6'h03;
        drive_payload();
        prev_data = data_in;
        #1;
        chk("m1_rdreq", 256'(rdreq_1), 256'(1));
        vectors++;
        @(negedge clk);
        chk("m1_low_index_valid_out", 256'(vo_1), 256'(6'h01));
        chk("m1_data_out", 256'(data_1), 256'(prev_data));
        chk("m1_garbage_out", 256'(garb_1), 256'(garbage_in));
        chk("m1_address_out", 256'(addr_1), 256'(address_in));
        chk("m1_lit_flag_out", 256'(lit_1), 256'(lit_flag_in));
        valid_in = 1'b0;
        ready    = 6'h3F;
        #1;
        chk("m1_empty_rdreq", 256'(rdreq_1), 256'(0));
        vectors++;
        @(negedge clk);
        chk("m1_empty_valid_out", 256'(vo_1), 256'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
